keypad_debounce_scan: RTL and testbench
=======================================

# keypad_debounce_scan

Upstream input stage of the tic-tac-toe game: drives the 3 keypad columns one-hot, samples the 4 row lines, debounces the 12-key matrix and presents a stable key image to the game controller. Each new single-key press also produces a one-cycle event, so the controller can place a stone, move the board or start a game exactly once per press. Output `key_data` feeds the game top directly.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each column stays driven. Minimum 4.
- `DEBOUNCE_FRAMES`, default 4: number of consecutive identical frames required before the debounced image changes. Range 2..15.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `key_row`  in  4  row sense lines. Active-high means pressed. Asynchronous to `clk`.
- `key_col`  out  3  column drive. One-hot, active-high.
- `key_data`  out  12  debounced key image. Bit k is set when key k is held.
- `key_press`  out  1  one-cycle pulse on a new single-key press.
- `key_code`  out  4  code of the last pressed key. 1..12 = key index+1; 0 = none since reset.

## Operation
- Key index k = row*3 + col. Labels:
  - k0..k8 = '1'..'9'
  - k9 = '*'
  - k10 = '0'
  - k11 = '#'
- `key_row` passes through a 2-flop synchronizer before any use.
- Column counter runs through states COL0 → COL1 → COL2 → COL0.
  - A divide counter of width clog2(SCAN_DIV) holds each state for SCAN_DIV cycles.
  - `key_col` = 001, 010, 100 respectively.
- Row sampling: the synchronized row is captured on the last dwell cycle of each column. This allows settling plus the 2-cycle synchronizer delay. The captured bits go into the frame register at bits {col+9, col+6, col+3, col}.
- Frame end is the last dwell cycle of COL2. At each frame end:
  - The snapshot is compared with the previous snapshot.
  - Equal: the stable counter increments, saturating at DEBOUNCE_FRAMES.
  - Different: the stable counter clears to 0 and the previous snapshot is replaced.
- When the stable counter reaches DEBOUNCE_FRAMES-1 at a frame end, `key_data` takes the snapshot. This happens once per stable run; later frames with the same snapshot do not re-trigger.
- Ghost and multi-key rule: a stable snapshot with more than one bit set loads `key_data` = 0.
- `key_press` asserts for one cycle when `key_data` goes from 0 to a single-bit value.
  - `key_code` updates in the same cycle and holds until the next press.
  - A release (→0) produces no pulse.
  - A direct change from one key to another without an intervening 0 frame produces no pulse.

## Timing
- Reset values:
  - `key_col` = 001
  - `key_data` = 0
  - `key_press` = 0
  - `key_code` = 0
  - all counters, snapshots and synchronizers = 0
- Frame period = 3*SCAN_DIV cycles.
- Press latency: `key_data` updates at the DEBOUNCE_FRAMES-th consecutive identical frame end.
  - The register updates on the clock edge after that frame-end cycle.
  - `key_press` is high in the first cycle where the new `key_data` is visible.
- Release latency: the same rule applies for the all-zero snapshot.
- A bounce that alters any single frame restarts the count. Worst case for a clean press is DEBOUNCE_FRAMES+1 frames.
- Reset mid-scan clears everything immediately (asynchronous). Scanning restarts at COL0 on the first edge after `rst` deasserts.
- `key_press` is never asserted on two consecutive cycles.

## Structure
- Shared package `ttt_pkg` holds:
  - KEY_W = 12 and KEY_CODE_W = 4
  - named key-index constants (KEY_1..KEY_9, KEY_STAR, KEY_0, KEY_HASH)
  - KEY_NONE = 0
  - These are also used by the game controller for placement and mode keys.
- Natural sub-module: `keypad_col_scan`. It contains the divide counter, column state, `key_col` drive, synchronizer and frame-end strobe.
- Debounce, popcount and press-detect logic live in the top of this block.

## Test plan
- Reset: hold `rst`=0 with `key_row`=1111. Required: `key_col`=001, `key_data`=0, `key_press`=0, `key_code`=0 throughout. After release, `key_col` steps 001→010→100 every SCAN_DIV cycles.
- Clean press (SCAN_DIV=4, DEBOUNCE_FRAMES=3): assert row1 only while col2 is driven ('6', k5), and hold it. Required:
  - `key_data`=0x020 after the 3rd identical frame end.
  - one `key_press` pulse, `key_code`=6.
  - releasing for 3 frames returns `key_data`=0 with no pulse.
- Bounce: toggle the '5' contact every frame for 5 frames, then hold it. Required:
  - no `key_data` change during toggling.
  - a single pulse, `key_code`=5, exactly 3 frames after the hold begins.
- Multi-key: hold '1' and '9' together for 6 frames. Required: `key_data` stays 0, no pulse. Then release '9' → pulse with `key_code`=1.
- Roll-over: hold '2' until `key_data`=0x002, then switch directly to '3' with no gap. Required: `key_data`=0x004, no second pulse, `key_code` stays 2.
- Async reset mid-press: assert `rst`=0 during the 2nd stable frame of a '#' press. Required: all outputs return to reset values at once. After release the debounce restarts: the pulse with `key_code`=12 arrives 3 full frames later.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: key image geometry, key-index constants
// and the keypad column-scan state encoding.
package ttt_pkg;

  localparam int KEY_W      = 12;
  localparam int KEY_CODE_W = 4;
  localparam int ROW_W      = 4;
  localparam int COL_W      = 3;

  // Key index k = row*3 + col; key_code reports k+1.
  localparam int KEY_1    = 0;
  localparam int KEY_2    = 1;
  localparam int KEY_3    = 2;
  localparam int KEY_4    = 3;
  localparam int KEY_5    = 4;
  localparam int KEY_6    = 5;
  localparam int KEY_7    = 6;
  localparam int KEY_8    = 7;
  localparam int KEY_9    = 8;
  localparam int KEY_STAR = 9;
  localparam int KEY_0    = 10;
  localparam int KEY_HASH = 11;

  localparam logic [KEY_CODE_W-1:0] KEY_NONE = '0;

  typedef enum logic [1:0] {
    COL0 = 2'd0,
    COL1 = 2'd1,
    COL2 = 2'd2
  } col_state_e;

endpackage

// File: rtl/keypad_debounce_scan_if.sv
// Keypad matrix lines plus the debounced key image handed to the game controller.
interface keypad_debounce_scan_if;
  import ttt_pkg::*;

  logic [ROW_W-1:0]      key_row;
  logic [COL_W-1:0]      key_col;
  logic [KEY_W-1:0]      key_data;
  logic                  key_press;
  logic [KEY_CODE_W-1:0] key_code;

  modport master (
    input  key_row,
    output key_col,
    output key_data,
    output key_press,
    output key_code
  );

  modport slave (
    output key_row,
    input  key_col,
    input  key_data,
    input  key_press,
    input  key_code
  );

endinterface

// File: rtl/keypad_col_scan.sv
// Column scanner: one-hot column drive, SCAN_DIV-cycle dwell per column,
// 2-flop row synchronizer and per-column sample / frame-end strobes.
module keypad_col_scan
  import ttt_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ROW_W-1:0] key_row,
  output logic [COL_W-1:0] key_col,
  output logic [ROW_W-1:0] row_sync,
  output logic             sample,
  output logic             frame_end
);

  localparam int              CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] div_cnt;
  logic             dwell_last;
  col_state_e       state;
  col_state_e       state_nxt;
  logic [ROW_W-1:0] row_p0;
  logic [ROW_W-1:0] row_p1;

  assign dwell_last = (div_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (dwell_last) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= COL0;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    key_col   = 3'b001;
    case (state)
      COL0: begin
        key_col = 3'b001;
        if (dwell_last) state_nxt = COL1;
      end
      COL1: begin
        key_col = 3'b010;
        if (dwell_last) state_nxt = COL2;
      end
      COL2: begin
        key_col = 3'b100;
        if (dwell_last) state_nxt = COL0;
      end
      default: begin
        key_col   = 3'b001;
        state_nxt = COL0;
      end
    endcase
  end

  // Synchronizer stages p0 -> p1; rows are only consumed from p1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_p0 <= '0;
      row_p1 <= '0;
    end else begin
      row_p0 <= key_row;
      row_p1 <= row_p0;
    end
  end

  assign row_sync  = row_p1;
  assign sample    = dwell_last;
  assign frame_end = dwell_last && (state == COL2);

endmodule

// File: rtl/keypad_debounce_scan.sv
// Keypad front end: scans the 3x4 matrix, debounces whole-frame snapshots and
// emits a one-cycle press event with the key code for each new single-key press.
module keypad_debounce_scan
  import ttt_pkg::*;
#(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  keypad_debounce_scan_if.master        kp
);

  localparam int               STB_W   = 4;
  localparam logic [STB_W-1:0] STB_MAX = STB_W'(DEBOUNCE_FRAMES);
  localparam logic [STB_W-1:0] STB_ARM = STB_W'(DEBOUNCE_FRAMES - 2);

  logic [COL_W-1:0]      col_drive;
  logic [ROW_W-1:0]      row_sync;
  logic                  sample;
  logic                  frame_end;

  logic [KEY_W-1:0]      frame_acc;
  logic [KEY_W-1:0]      snap;
  logic [KEY_W-1:0]      prev_snap;
  logic [STB_W-1:0]      stable_cnt;
  logic [STB_W-1:0]      stable_nxt;
  logic                  same;
  logic                  load;
  logic [3:0]            snap_bits;
  logic [KEY_W-1:0]      load_val;
  logic                  press_nxt;

  logic [KEY_W-1:0]      key_data_q;
  logic                  key_press_q;
  logic [KEY_CODE_W-1:0] key_code_q;

  function automatic logic [3:0] popcount(input logic [KEY_W-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < KEY_W; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  function automatic logic [KEY_CODE_W-1:0] key_code_of(input logic [KEY_W-1:0] v);
    logic [KEY_CODE_W-1:0] c;
    c = KEY_NONE;
    for (int i = 0; i < KEY_W; i++) begin
      if (v[i]) c = KEY_CODE_W'(i + 1);
    end
    return c;
  endfunction

  keypad_col_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .key_row   (kp.key_row),
    .key_col   (col_drive),
    .row_sync  (row_sync),
    .sample    (sample),
    .frame_end (frame_end)
  );

  // Overlay the column being sampled now onto the bits captured earlier in the frame.
  always_comb begin
    snap = frame_acc;
    for (int r = 0; r < ROW_W; r++) begin
      for (int c = 0; c < COL_W; c++) begin
        if (col_drive[c]) snap[r*COL_W + c] = row_sync[r];
      end
    end
  end

  assign same = (snap == prev_snap);

  always_comb begin
    stable_nxt = stable_cnt;
    if (!same) begin
      stable_nxt = '0;
    end else if (stable_cnt != STB_MAX) begin
      stable_nxt = stable_cnt + STB_W'(1);
    end
  end

  // Fires only on the increment into DEBOUNCE_FRAMES-1, so a saturated run never reloads.
  assign load      = frame_end && same && (stable_cnt == STB_ARM);
  assign snap_bits = popcount(snap);
  assign load_val  = (snap_bits > 4'd1) ? '0 : snap;
  assign press_nxt = load && (key_data_q == '0) && (snap_bits == 4'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_acc  <= '0;
      prev_snap  <= '0;
      stable_cnt <= '0;
    end else begin
      if (sample) frame_acc <= snap;
      if (frame_end) begin
        stable_cnt <= stable_nxt;
        if (!same) prev_snap <= snap;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_data_q  <= '0;
      key_press_q <= 1'b0;
      key_code_q  <= KEY_NONE;
    end else begin
      key_press_q <= press_nxt;
      if (load)      key_data_q <= load_val;
      if (press_nxt) key_code_q <= key_code_of(snap);
    end
  end

  assign kp.key_col   = col_drive;
  assign kp.key_data  = key_data_q;
  assign kp.key_press = key_press_q;
  assign kp.key_code  = key_code_q;

endmodule

// File: tb/tb_keypad_debounce_scan.sv
// Directed bench for keypad_debounce_scan with SCAN_DIV=4, DEBOUNCE_FRAMES=3
// and a behavioural key matrix driven from a held-key mask.
module tb_keypad_debounce_scan;
  import ttt_pkg::*;

  localparam int SD    = 4;
  localparam int DF    = 3;
  localparam int FRAME = 3 * SD;
  localparam int NVEC  = 40;

  logic clk = 1'b0;
  logic rst = 1'b0;

  keypad_debounce_scan_if kif ();

  keypad_debounce_scan #(
    .SCAN_DIV        (SD),
    .DEBOUNCE_FRAMES (DF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kif.master)
  );

  always #5 clk = ~clk;

  logic [KEY_W-1:0] held       = '0;
  logic             force_rows = 1'b0;

  // Key (r,c) closed pulls row r high while column c is driven.
  always_comb begin
    kif.key_row = '0;
    if (force_rows) begin
      kif.key_row = '1;
    end else begin
      for (int r = 0; r < ROW_W; r++) begin
        for (int c = 0; c < COL_W; c++) begin
          if (kif.key_col[c] && held[r*COL_W + c]) kif.key_row[r] = 1'b1;
        end
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int   press_seen   = 0;
  int   double_press = 0;
  logic press_last   = 1'b0;

  always @(negedge clk) begin
    if (kif.key_press) press_seen++;
    if (kif.key_press && press_last) double_press++;
    press_last = kif.key_press;
  end

  typedef struct {
    logic [KEY_W-1:0]      held;
    logic [KEY_W-1:0]      data;
    logic                  press;
    logic [KEY_CODE_W-1:0] code;
  } vec_t;

  vec_t vecs [NVEC];

  initial begin
    // One row per frame: keys held during the frame, outputs just after its frame end.
    vecs = '{
      '{12'h000, 12'h000, 1'b0, 4'd0},
      '{12'h020, 12'h000, 1'b0, 4'd0},
      '{12'h020, 12'h000, 1'b0, 4'd0},
      '{12'h020, 12'h020, 1'b1, 4'd6},
      '{12'h020, 12'h020, 1'b0, 4'd6},
      '{12'h000, 12'h020, 1'b0, 4'd6},
      '{12'h000, 12'h020, 1'b0, 4'd6},
      '{12'h000, 12'h000, 1'b0, 4'd6},
      '{12'h000, 12'h000, 1'b0, 4'd6},
      '{12'h010, 12'h000, 1'b0, 4'd6},
      '{12'h000, 12'h000, 1'b0, 4'd6},
      '{12'h010, 12'h000, 1'b0, 4'd6},
      '{12'h000, 12'h000, 1'b0, 4'd6},
      '{12'h010, 12'h000, 1'b0, 4'd6},
      '{12'h010, 12'h000, 1'b0, 4'd6},
      '{12'h010, 12'h010, 1'b1, 4'd5},
      '{12'h000, 12'h010, 1'b0, 4'd5},
      '{12'h000, 12'h010, 1'b0, 4'd5},
      '{12'h000, 12'h000, 1'b0, 4'd5},
      '{12'h101, 12'h000, 1'b0, 4'd5},
      '{12'h101, 12'h000, 1'b0, 4'd5},
      '{12'h101, 12'h000, 1'b0, 4'd5},
      '{12'h101, 12'h000, 1'b0, 4'd5},
      '{12'h101, 12'h000, 1'b0, 4'd5},
      '{12'h101, 12'h000, 1'b0, 4'd5},
      '{12'h001, 12'h000, 1'b0, 4'd5},
      '{12'h001, 12'h000, 1'b0, 4'd5},
      '{12'h001, 12'h001, 1'b1, 4'd1},
      '{12'h000, 12'h001, 1'b0, 4'd1},
      '{12'h000, 12'h001, 1'b0, 4'd1},
      '{12'h000, 12'h000, 1'b0, 4'd1},
      '{12'h002, 12'h000, 1'b0, 4'd1},
      '{12'h002, 12'h000, 1'b0, 4'd1},
      '{12'h002, 12'h002, 1'b1, 4'd2},
      '{12'h004, 12'h002, 1'b0, 4'd2},
      '{12'h004, 12'h002, 1'b0, 4'd2},
      '{12'h004, 12'h004, 1'b0, 4'd2},
      '{12'h000, 12'h004, 1'b0, 4'd2},
      '{12'h000, 12'h004, 1'b0, 4'd2},
      '{12'h000, 12'h000, 1'b0, 4'd2}
    };

    // Reset held with every row line active.
    force_rows = 1'b1;
    rst        = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check($sformatf("rst%0d key_col", i),   32'(kif.key_col),   32'h1);
      check($sformatf("rst%0d key_data", i),  32'(kif.key_data),  32'h0);
      check($sformatf("rst%0d key_press", i), 32'(kif.key_press), 32'h0);
      check($sformatf("rst%0d key_code", i),  32'(kif.key_code),  32'h0);
    end
    @(negedge clk);
    force_rows = 1'b0;
    rst        = 1'b1;

    // Column stepping over the first frame after reset.
    tick(SD - 1);
    check("step col0", 32'(kif.key_col), 32'h1);
    tick(1);
    check("step col1", 32'(kif.key_col), 32'h2);
    tick(SD);
    check("step col2", 32'(kif.key_col), 32'h4);
    tick(SD);
    check("step wrap", 32'(kif.key_col), 32'h1);
    check("frame1 key_data", 32'(kif.key_data), 32'h0);

    for (int i = 0; i < NVEC; i++) begin
      held = vecs[i].held;
      tick(FRAME);
      check($sformatf("v%0d key_data", i),  32'(kif.key_data),  32'(vecs[i].data));
      check($sformatf("v%0d key_press", i), 32'(kif.key_press), 32'(vecs[i].press));
      check($sformatf("v%0d key_code", i),  32'(kif.key_code),  32'(vecs[i].code));
      check($sformatf("v%0d key_col", i),   32'(kif.key_col),   32'h1);
    end
    check("table press count", 32'(press_seen), 32'd4);

    // '#' press interrupted by reset during its second stable frame.
    held = 12'h800;
    tick(FRAME);
    check("hash f1 key_data", 32'(kif.key_data), 32'h0);
    tick(5);
    check("hash mid key_col", 32'(kif.key_col), 32'h2);
    rst = 1'b0;
    #1;
    check("async key_col",   32'(kif.key_col),   32'h1);
    check("async key_data",  32'(kif.key_data),  32'h0);
    check("async key_press", 32'(kif.key_press), 32'h0);
    check("async key_code",  32'(kif.key_code),  32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick(FRAME);
    check("hash r1 key_data",  32'(kif.key_data),  32'h0);
    check("hash r1 key_press", 32'(kif.key_press), 32'h0);
    tick(FRAME);
    check("hash r2 key_data",  32'(kif.key_data),  32'h0);
    check("hash r2 key_press", 32'(kif.key_press), 32'h0);
    tick(FRAME);
    check("hash r3 key_data",  32'(kif.key_data),  32'h800);
    check("hash r3 key_press", 32'(kif.key_press), 32'h1);
    check("hash r3 key_code",  32'(kif.key_code),  32'd12);
    tick(1);
    check("hash pulse width", 32'(kif.key_press), 32'h0);
    check("hash hold data",   32'(kif.key_data),  32'h800);

    tick(2 * FRAME);
    check("hash no repeat", 32'(kif.key_code), 32'd12);
    check("total presses",  32'(press_seen),   32'd5);
    check("back-to-back presses", 32'(double_press), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
